// File: rtl/decode_stage_hz.sv
// decode_stage_hz: RISC-V decode with register file, W-stage bypass, load-use stall and ID/EX register
module decode_stage_hz #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            ValidD,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            StallD,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [4:0]      RD_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic            ValidE,
  output logic            IllegalE
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
    logic            illegal;
  } idex_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic is_lw, is_sw, is_r, is_i, is_beq, legal, use_rs2, bubble;
  logic [2:0] alu_f3, alu_ctrl;
  logic [XLEN-1:0] imm, rd1, rd2;
  logic [XLEN-1:0] rf [NREG];
  idex_t e_d, e_q;

  assign op  = InstrD[6:0];
  assign f3  = InstrD[14:12];
  assign rd  = InstrD[11:7];
  assign rs1 = InstrD[19:15];
  assign rs2 = InstrD[24:20];

  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_r    = op == OP_R;
  assign is_i    = op == OP_I;
  assign is_beq  = op == OP_BEQ;
  assign legal   = is_lw | is_sw | is_r | is_i | is_beq;
  assign use_rs2 = is_r | is_sw | is_beq;

  // funct7[5] only selects sub for register-register ops; addi keeps add
  assign alu_f3 = f3 == 3'b000 ? {2'b00, is_r & InstrD[30]} :
                  f3 == 3'b010 ? 3'b101 :
                  f3 == 3'b110 ? 3'b011 :
                  f3 == 3'b111 ? 3'b010 : 3'b000;
  assign alu_ctrl = is_beq ? 3'b001 : (is_r | is_i) ? alu_f3 : 3'b000;

  assign imm = (is_lw | is_i) ? {{(XLEN-12){InstrD[31]}}, InstrD[31:20]} :
               is_sw ? {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
               is_beq ? {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} :
               '0;

  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0 || 32'(a) >= NREG) return '0;
    if (BYPASS_EN != 0 && RegWriteW && RDW == a) return ResultW;
    return rf[a[AW-1:0]];
  endfunction

  always_comb begin
    rd1 = rd_reg(rs1);
    rd2 = rd_reg(rs2);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (RegWriteW && RDW != 5'd0 && 32'(RDW) < NREG)
      rf[RDW[AW-1:0]] <= ResultW;

  assign StallD = ValidD & ValidE & ResultSrcE & RegWriteE & (RD_E != 5'd0) &
                  (((RD_E == rs1) & legal) | ((RD_E == rs2) & use_rs2));

  assign bubble = FlushE | StallD | ~ValidD;
  assign e_d = bubble ? '0 : {is_lw | is_r | is_i, is_lw | is_sw | is_i, is_sw, is_lw, is_beq,
                              alu_ctrl, rd1, rd2, imm, rs1, rs2, rd, PCD, PCPlus4D, 1'b1, ~legal};

  always_ff @(posedge clk or negedge rst)
    if (!rst) e_q <= '0;
    else e_q <= e_d;

  assign {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, RD1_E, RD2_E,
          Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E, ValidE, IllegalE} = e_q;
endmodule

// File: tb/tb_decode_stage_hz.sv
// tb_decode_stage_hz: directed table and sequence checks of decode_stage_hz (32-bit default and 64-bit/NREG=16/no-bypass)
module tb_decode_stage_hz;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pcd = '0, pcp4 = '0, resw = '0;
  logic valid_d = 1'b0, flush = 1'b0, rw_w = 1'b0;
  logic [4:0] rdw = '0;

  logic stall, rwe, alusrc, mwe, rse, bre, ve, ile;
  logic [2:0] aluc;
  logic [31:0] rd1, rd2, imm, pce, pcp4e;
  logic [4:0] rs1e, rs2e, rde;

  logic w_stall, w_rwe, w_alusrc, w_mwe, w_rse, w_bre, w_ve, w_ile;
  logic [2:0] w_aluc;
  logic [63:0] w_rd1, w_rd2, w_imm, w_pce, w_pcp4e;
  logic [4:0] w_rs1e, w_rs2e, w_rde;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage_hz u (
    .clk(clk), .rst(rst), .InstrD(instr), .PCD(pcd[31:0]), .PCPlus4D(pcp4[31:0]),
    .ValidD(valid_d), .FlushE(flush), .RegWriteW(rw_w), .RDW(rdw), .ResultW(resw[31:0]),
    .StallD(stall), .RegWriteE(rwe), .ALUSrcE(alusrc), .MemWriteE(mwe), .ResultSrcE(rse),
    .BranchE(bre), .ALUControlE(aluc), .RD1_E(rd1), .RD2_E(rd2), .Imm_Ext_E(imm),
    .RS1_E(rs1e), .RS2_E(rs2e), .RD_E(rde), .PCE(pce), .PCPlus4E(pcp4e),
    .ValidE(ve), .IllegalE(ile)
  );

  decode_stage_hz #(.XLEN(64), .NREG(16), .BYPASS_EN(0)) u64 (
    .clk(clk), .rst(rst), .InstrD(instr), .PCD(pcd), .PCPlus4D(pcp4),
    .ValidD(valid_d), .FlushE(flush), .RegWriteW(rw_w), .RDW(rdw), .ResultW(resw),
    .StallD(w_stall), .RegWriteE(w_rwe), .ALUSrcE(w_alusrc), .MemWriteE(w_mwe), .ResultSrcE(w_rse),
    .BranchE(w_bre), .ALUControlE(w_aluc), .RD1_E(w_rd1), .RD2_E(w_rd2), .Imm_Ext_E(w_imm),
    .RS1_E(w_rs1e), .RS2_E(w_rs2e), .RD_E(w_rde), .PCE(w_pce), .PCPlus4E(w_pcp4e),
    .ValidE(w_ve), .IllegalE(w_ile)
  );

  typedef struct {
    logic [31:0] instr;
    logic        vd;
    logic        fl;
    logic [4:0]  ctrl;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ve;
    logic        il;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] in, input logic vd, input logic fl);
    instr = in;
    valid_d = vd;
    flush = fl;
  endtask

  task automatic wreg(input logic [4:0] r, input logic [63:0] v);
    rw_w = 1'b1;
    rdw = r;
    resw = v;
    tick();
    rw_w = 1'b0;
  endtask

  localparam logic [31:0] I_LW7  = 32'h00812383;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADD5 = 32'h00028333;
  localparam logic [31:0] I_USE7 = 32'h00138433;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{I_ADD5,       1'b1, 1'b0, 5'b10000, 3'b000, 32'h0,        5'd5, 5'd0,  5'd6,  1'b1, 1'b0};
    tv[1]  = '{I_SUB,        1'b1, 1'b0, 5'b10000, 3'b001, 32'h0,        5'd1, 5'd2,  5'd3,  1'b1, 1'b0};
    tv[2]  = '{I_LW7,        1'b1, 1'b0, 5'b11010, 3'b000, 32'h8,        5'd2, 5'd8,  5'd7,  1'b1, 1'b0};
    tv[3]  = '{32'hFE20AE23, 1'b1, 1'b0, 5'b01100, 3'b000, 32'hFFFFFFFC, 5'd1, 5'd2,  5'd28, 1'b1, 1'b0};
    tv[4]  = '{32'hFE000CE3, 1'b1, 1'b0, 5'b00001, 3'b001, 32'hFFFFFFF8, 5'd0, 5'd0,  5'd25, 1'b1, 1'b0};
    tv[5]  = '{32'hFFF08293, 1'b1, 1'b0, 5'b11000, 3'b000, 32'hFFFFFFFF, 5'd1, 5'd31, 5'd5,  1'b1, 1'b0};
    tv[6]  = '{32'h0050A293, 1'b1, 1'b0, 5'b11000, 3'b101, 32'h5,        5'd1, 5'd5,  5'd5,  1'b1, 1'b0};
    tv[7]  = '{32'h0020E233, 1'b1, 1'b0, 5'b10000, 3'b011, 32'h0,        5'd1, 5'd2,  5'd4,  1'b1, 1'b0};
    tv[8]  = '{32'h0F00F213, 1'b1, 1'b0, 5'b11000, 3'b010, 32'hF0,       5'd1, 5'd16, 5'd4,  1'b1, 1'b0};
    tv[9]  = '{32'h40008093, 1'b1, 1'b0, 5'b11000, 3'b000, 32'h400,      5'd1, 5'd0,  5'd1,  1'b1, 1'b0};
    tv[10] = '{32'h001090B3, 1'b1, 1'b0, 5'b10000, 3'b000, 32'h0,        5'd1, 5'd1,  5'd1,  1'b1, 1'b0};
    tv[11] = '{32'h0000007F, 1'b1, 1'b0, 5'b00000, 3'b000, 32'h0,        5'd0, 5'd0,  5'd0,  1'b1, 1'b1};
    tv[12] = '{32'h000010B7, 1'b1, 1'b0, 5'b00000, 3'b000, 32'h0,        5'd0, 5'd0,  5'd1,  1'b1, 1'b1};
    tv[13] = '{I_ADD5,       1'b0, 1'b0, 5'b00000, 3'b000, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b0};
    tv[14] = '{I_SUB,        1'b1, 1'b1, 5'b00000, 3'b000, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b0};
    tv[15] = '{I_LW7,        1'b1, 1'b0, 5'b11010, 3'b000, 32'h8,        5'd2, 5'd8,  5'd7,  1'b1, 1'b0};
    tv[16] = '{I_USE7,       1'b0, 1'b0, 5'b00000, 3'b000, 32'h0,        5'd0, 5'd0,  5'd0,  1'b0, 1'b0};

    #3;
    chk("reset ValidE", ve, 0);
    chk("reset RegWriteE", rwe, 0);
    chk("reset PCE", pce, 0);
    chk("reset64 ValidE", w_ve, 0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].instr, tv[i].vd, tv[i].fl);
      pcd = 64'h1000 + 64'(i * 4);
      pcp4 = pcd + 64'd4;
      #1;
      chk($sformatf("row%0d StallD", i), stall, 0);
      tick();
      chk($sformatf("row%0d ctrl", i), {rwe, alusrc, mwe, rse, bre}, tv[i].ctrl);
      chk($sformatf("row%0d ALUControlE", i), aluc, tv[i].alu);
      chk($sformatf("row%0d Imm_Ext_E", i), imm, tv[i].imm);
      chk($sformatf("row%0d RS1_E", i), rs1e, tv[i].rs1);
      chk($sformatf("row%0d RS2_E", i), rs2e, tv[i].rs2);
      chk($sformatf("row%0d RD_E", i), rde, tv[i].rd);
      chk($sformatf("row%0d ValidE", i), ve, tv[i].ve);
      chk($sformatf("row%0d IllegalE", i), ile, tv[i].il);
      chk($sformatf("row%0d PCE", i), pce, tv[i].ve ? 64'h1000 + 64'(i * 4) : 64'h0);
      chk($sformatf("row%0d PCPlus4E", i), pcp4e, tv[i].ve ? 64'h1004 + 64'(i * 4) : 64'h0);
      chk($sformatf("row%0d ctrl64", i), {w_rwe, w_alusrc, w_mwe, w_rse, w_bre}, tv[i].ctrl);
      chk($sformatf("row%0d Imm64", i), w_imm, {{32{tv[i].imm[31]}}, tv[i].imm});
    end

    drive(32'h0, 1'b0, 1'b0);
    wreg(5'd1, 64'h11);
    wreg(5'd2, 64'h22);
    wreg(5'd5, 64'h55);
    wreg(5'd20, 64'hABCD);
    wreg(5'd0, 64'hDEAD);

    drive(I_ADD5, 1'b1, 1'b0);
    rw_w = 1'b1; rdw = 5'd5; resw = 64'h1234;
    tick();
    rw_w = 1'b0;
    chk("bypass RD1_E", rd1, 32'h1234);
    chk("bypass RegWriteE", rwe, 1);
    chk("bypass ALUControlE", aluc, 0);
    chk("nobypass RD1_E old x5", w_rd1, 64'h55);
    tick();
    chk("after write RD1_E", rd1, 32'h1234);
    chk("after write 64 RD1_E", w_rd1, 64'h1234);
    drive(I_SUB, 1'b1, 1'b0);
    tick();
    chk("sub RD1_E x1", rd1, 32'h11);
    chk("sub RD2_E x2", rd2, 32'h22);
    chk("sub64 RD2_E x2", w_rd2, 64'h22);
    drive(32'h000A0333, 1'b1, 1'b0);
    tick();
    chk("x20 RD1_E", rd1, 32'hABCD);
    chk("x20 NREG16 RD1_E", w_rd1, 64'h0);
    drive(32'h00020333, 1'b1, 1'b0);
    tick();
    chk("x4 NREG16 RD1_E", w_rd1, 64'h0);
    chk("x4 RD1_E", rd1, 32'h0);
    drive(32'h00000333, 1'b1, 1'b0);
    rw_w = 1'b1; rdw = 5'd0; resw = 64'hBEEF;
    tick();
    rw_w = 1'b0;
    chk("x0 RD1_E", rd1, 32'h0);
    chk("x0 64 RD1_E", w_rd1, 64'h0);

    drive(I_SUB, 1'b1, 1'b1);
    tick();
    chk("flush ValidE", ve, 0);
    chk("flush ctrl", {rwe, alusrc, mwe, rse, bre, aluc}, 0);
    drive(I_SUB, 1'b1, 1'b0);
    tick();
    chk("post flush ALUControlE", aluc, 3'b001);
    chk("post flush ValidE", ve, 1);

    drive(I_LW7, 1'b1, 1'b0);
    tick();
    chk("lw ResultSrcE", rse, 1);
    drive(I_USE7, 1'b1, 1'b0);
    #1;
    chk("loaduse StallD", stall, 1);
    chk("loaduse64 StallD", w_stall, 1);
    tick();
    chk("stall bubble ValidE", ve, 0);
    chk("stall bubble RegWriteE", rwe, 0);
    #1;
    chk("stall one cycle StallD", stall, 0);
    tick();
    chk("reissue ValidE", ve, 1);
    chk("reissue RS1_E", rs1e, 7);
    chk("reissue RD_E", rde, 8);
    chk("reissue RD2_E x1", rd2, 32'h11);

    drive(32'h00812003, 1'b1, 1'b0);
    tick();
    drive(32'h00100433, 1'b1, 1'b0);
    #1;
    chk("lw x0 StallD", stall, 0);
    tick();

    drive(I_LW7, 1'b1, 1'b0);
    tick();
    drive(32'h0070A023, 1'b1, 1'b0);
    #1;
    chk("sw rs2 StallD", stall, 1);
    tick();
    chk("sw stall ValidE", ve, 0);
    tick();
    chk("sw reissue MemWriteE", mwe, 1);
    chk("sw reissue RS2_E", rs2e, 7);

    drive(I_LW7, 1'b1, 1'b0);
    tick();
    drive(32'h00708493, 1'b1, 1'b0);
    #1;
    chk("addi rs2 field unused StallD", stall, 0);
    tick();

    drive(I_LW7, 1'b1, 1'b0);
    tick();
    drive(I_USE7, 1'b1, 1'b1);
    #1;
    chk("flush+stall StallD", stall, 1);
    tick();
    chk("flush+stall ValidE", ve, 0);

    drive(I_SUB, 1'b1, 1'b0);
    tick();
    chk("pre reset ValidE", ve, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset ValidE", ve, 0);
    chk("async reset ctrl", {rwe, aluc}, 0);
    chk("async reset RD1_E", rd1, 0);
    chk("async reset PCE", pce, 0);
    chk("async reset RD_E", rde, 0);
    tick();
    rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      drive({7'b0, r, r, 3'b000, 5'd6, 7'b0110011}, 1'b1, 1'b0);
      tick();
      chk($sformatf("post reset x%0d", i), rd1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
- Parametrised decode stage plus ID/EX pipeline register for the 5-stage RISC-V core.
- Decodes the D-stage instruction (control, ALU op, immediate) and reads a built-in register file with a write-through bypass from W.
- Adds load-use hazard detection (stall request to IF/ID and PC), flush, a valid bit and an illegal-opcode flag.
- Registers everything into the E stage.

Parameters:
XLEN, 32, datapath width (32 or 64); PC, immediates, register data.
NREG, 32, architectural register count (2..32); addresses >= NREG read 0 and ignore writes.
BYPASS_EN, 1, 1 = same-cycle W write is visible on D read; 0 = read returns old value.

Ports:
clk  in  1  clock, posedge
rst  in  1  asynchronous, active-low reset
InstrD  in  32  instruction in D
PCD  in  XLEN  PC of InstrD
PCPlus4D  in  XLEN  PC+4 of InstrD
ValidD  in  1  InstrD is a real instruction
FlushE  in  1  insert bubble into ID/EX (taken branch)
RegWriteW  in  1  W-stage write enable
RDW  in  5  W-stage destination
ResultW  in  XLEN  W-stage write data
StallD  out  1  combinational; hold PC and IF/ID this cycle
RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  E controls
ALUControlE  out  3  000 add, 001 sub, 101 slt, 011 or, 010 and
RD1_E, RD2_E, Imm_Ext_E  out  XLEN  operands, extended immediate
RS1_E, RS2_E, RD_E  out  5  register addresses
PCE, PCPlus4E  out  XLEN  pipelined PCs
ValidE  out  1  E holds a real instruction
IllegalE  out  1  E instruction had an unsupported opcode

Behaviour:
- Reset: all E outputs and all registers x1..xNREG-1 are 0; async assert, sync-safe deassert. Reset mid-operation discards ID/EX contents immediately.

Register file:
- x0 always reads 0.
- Write at posedge when RegWriteW=1, RDW!=0 and RDW<NREG.
- Read ports are combinational, A1=InstrD[19:15], A2=InstrD[24:20].
- Bypass: when BYPASS_EN=1, RegWriteW=1, RDW==A, A!=0 and A<NREG, the read returns ResultW.

Decode by opcode (RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, ImmSrc):
- 0000011 lw: 1,1,0,1,0,I.
- 0100011 sw: 0,1,1,0,0,S.
- 0110011 R: 1,0,0,0,0,none.
- 0010011 I-ALU: 1,1,0,0,0,I.
- 1100011 beq: 0,0,0,0,1,B.
- Any other opcode: all controls 0, Illegal=1.

ALUControl:
- lw/sw -> add; beq -> sub.
- R/I-ALU by funct3:
  - 000 -> sub if R and funct7[5]=1, else add.
  - 010 -> slt.
  - 110 -> or.
  - 111 -> and.
  - others -> add.

Immediates, sign-extended from bit 31 to XLEN:
- I = [31:20].
- S = {[31:25],[11:7]}.
- B = {[31],[7],[30:25],[11:8],1'b0}.
- none -> 0.

Hazard detection (combinational):
- Operand use: rs1 used by every legal opcode; rs2 used by R, sw, beq.
- StallD = ValidD & ValidE & ResultSrcE & RegWriteE & (RD_E!=0) & ((RD_E==rs1 & rs1 used) | (RD_E==rs2 & rs2 used)).

ID/EX update each posedge, priority high to low:
1. FlushE=1 or StallD=1 or ValidD=0: load a bubble. Bubble = all controls 0, ValidE=0, IllegalE=0, all data/address fields 0.
2. Otherwise load the decoded values: RD_E=InstrD[11:7], RS1_E/RS2_E from InstrD, ValidE=1, IllegalE per decode.

Latency and boundary rules:
- Latency D->E is exactly 1 cycle; no internal holding state beyond ID/EX.
- FlushE together with StallD: bubble. StallD may still be 1 that cycle; IF/ID hold is harmless.
- A stalled instruction re-presents next cycle; the E bubble then clears the hazard, so a stall lasts exactly 1 cycle.
- A write to RDW>=NREG is dropped; with NREG=16, x20 reads 0.

Test Plan:
- Reset: rst low mid-stream with ValidE=1 -> all E outputs 0 immediately; after release, x1..x31 read 0.
- Bypass: RegWriteW=1, RDW=5, ResultW=0x1234 while InstrD=add x6,x5,x0 (0x00028333) -> next cycle RD1_E=0x1234, RegWriteE=1, ALUControlE=000; repeat with BYPASS_EN=0 -> RD1_E=old x5 value.
- Load-use: E holds lw x7 (ValidE=1); InstrD=add x8,x7,x1 -> StallD=1, next cycle ValidE=0, RegWriteE=0; following cycle add enters with RS1_E=7. Same with lw x0 -> StallD=0. Same with sw x7 as rs2 -> stall.
- Flush: FlushE=1 with InstrD=sub x3,x1,x2 -> next cycle ValidE=0, all controls 0; FlushE=0 next -> ALUControlE=001.
- Immediates: sw x2,-4(x1) (0xFE20AE23) -> Imm_Ext_E=0xFFFFFFFC, MemWriteE=1; beq x0,x0,-8 (0xFE000CE3) -> Imm_Ext_E=0xFFFFFFF8, BranchE=1; XLEN=64 -> 0xFFFFFFFFFFFFFFF8.
- Illegal: InstrD=0x0000007F, ValidD=1 -> ValidE=1, IllegalE=1, all controls 0; write to x0 via W -> x0 reads 0.
